// File: rtl/mux_4x1_8bits_tx.sv
// mux_4x1_8bits_tx: TX lane merger. Accepts a group of four lane bytes with
// per-lane valid flags through a ready/valid handshake and serializes them
// onto one byte stream in lane order 0..3, one slot per cycle. Invalid lanes
// keep their slot but present a masked (zero) byte.
//
// Ports:
//   clk                 rising-edge clock
//   reset               synchronous, active-high reset
//   data_in0..3         lane bytes of the offered group
//   valid_in0..3        per-lane valid of the offered group
//   in_valid            group offered this cycle
//   in_ready            combinational; accept when in_valid & in_ready
//   data_out            serialized byte (registered, zero when lane invalid)
//   valid_out           valid flag of the lane in the current slot (registered)
//   lane_idx            lane number of the current slot (registered)
//   active              a slot is being presented (registered)
module mux_4x1_8bits_tx #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in0,
  input  logic [DATA_W-1:0] data_in1,
  input  logic [DATA_W-1:0] data_in2,
  input  logic [DATA_W-1:0] data_in3,
  input  logic              valid_in0,
  input  logic              valid_in1,
  input  logic              valid_in2,
  input  logic              valid_in3,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic [1:0]        lane_idx,
  output logic              active
);

  localparam int unsigned LANES = 4;
  localparam int unsigned CNT_W = 2;
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(LANES - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                         state, state_n;
  logic [CNT_W-1:0]               cnt, cnt_n;
  logic [LANES-1:0][DATA_W-1:0]   hold_data, hold_data_n;
  logic [LANES-1:0]               hold_valid, hold_valid_n;
  logic [DATA_W-1:0]              data_out_n;
  logic                           valid_out_n;
  logic [1:0]                     lane_idx_n;
  logic                           active_n;
  logic                           accept;
  logic [CNT_W-1:0]               nxt_slot;

  // Ready in IDLE and during the lane-3 slot, so groups can run back to back.
  assign in_ready = !reset && ((state == IDLE) || ((state == SEND) && (cnt == LAST_SLOT)));
  assign accept   = in_valid && in_ready;
  assign nxt_slot = cnt + CNT_W'(1);

  // Next-state and next-output logic.
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    hold_data_n  = hold_data;
    hold_valid_n = hold_valid;
    data_out_n   = data_out;
    valid_out_n  = valid_out;
    lane_idx_n   = lane_idx;
    active_n     = active;

    if (accept) begin
      hold_data_n  = {data_in3, data_in2, data_in1, data_in0};
      hold_valid_n = {valid_in3, valid_in2, valid_in1, valid_in0};
      data_out_n   = valid_in0 ? data_in0 : '0;
      valid_out_n  = valid_in0;
      lane_idx_n   = 2'd0;
      active_n     = 1'b1;
      cnt_n        = '0;
      state_n      = SEND;
    end else if ((state == SEND) && (cnt != LAST_SLOT)) begin
      // Invalid lanes still take their slot but present a zero byte.
      cnt_n       = nxt_slot;
      data_out_n  = hold_valid[nxt_slot] ? hold_data[nxt_slot] : '0;
      valid_out_n = hold_valid[nxt_slot];
      lane_idx_n  = 2'(nxt_slot);
      active_n    = 1'b1;
    end else begin
      state_n     = IDLE;
      cnt_n       = '0;
      data_out_n  = '0;
      valid_out_n = 1'b0;
      lane_idx_n  = 2'd0;
      active_n    = 1'b0;
    end
  end

  // State and output registers; reset discards any group in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      hold_data  <= '0;
      hold_valid <= '0;
      data_out   <= '0;
      valid_out  <= 1'b0;
      lane_idx   <= 2'd0;
      active     <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      hold_data  <= hold_data_n;
      hold_valid <= hold_valid_n;
      data_out   <= data_out_n;
      valid_out  <= valid_out_n;
      lane_idx   <= lane_idx_n;
      active     <= active_n;
    end
  end

endmodule

// File: tb/tb_mux_4x1_8bits_tx.sv
// tb_mux_4x1_8bits_tx: directed plus randomized stimulus against a queue-based
// slot model of the lane merger.
module tb_mux_4x1_8bits_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] din [4];
  logic       vin [4];
  logic       in_valid;
  logic       in_ready;
  logic [7:0] data_out;
  logic       valid_out;
  logic [1:0] lane_idx;
  logic       active;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [7:0] d;
    logic       v;
    logic [1:0] l;
  } slot_t;

  slot_t      pend_q[$];
  slot_t      cur;
  logic       cur_active;

  always #5 clk = ~clk;

  mux_4x1_8bits_tx #(.DATA_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .data_in0  (din[0]),
    .data_in1  (din[1]),
    .data_in2  (din[2]),
    .data_in3  (din[3]),
    .valid_in0 (vin[0]),
    .valid_in1 (vin[1]),
    .valid_in2 (vin[2]),
    .valid_in3 (vin[3]),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_out  (data_out),
    .valid_out (valid_out),
    .lane_idx  (lane_idx),
    .active    (active)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One cycle: check ready before the edge, update the model at the edge,
  // then check registered outputs just after it.
  task automatic tick(input string tag);
    logic exp_ready;
    #1;
    exp_ready = !reset && (pend_q.size() == 0);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(exp_ready));
    @(posedge clk);
    if (reset) begin
      pend_q.delete();
      cur        = '0;
      cur_active = 1'b0;
    end else if (in_valid && exp_ready) begin
      for (int i = 0; i < 4; i++) begin
        slot_t s;
        s.d = vin[i] ? din[i] : 8'h00;
        s.v = vin[i];
        s.l = 2'(i);
        if (i == 0) cur = s;
        else pend_q.push_back(s);
      end
      cur_active = 1'b1;
    end else if (pend_q.size() != 0) begin
      cur        = pend_q.pop_front();
      cur_active = 1'b1;
    end else begin
      cur        = '0;
      cur_active = 1'b0;
    end
    #1;
    chk({tag, ".data_out"},  32'(data_out),  32'(cur.d));
    chk({tag, ".valid_out"}, 32'(valid_out), 32'(cur.v));
    chk({tag, ".lane_idx"},  32'(lane_idx),  32'(cur.l));
    chk({tag, ".active"},    32'(active),    32'(cur_active));
    @(negedge clk);
  endtask

  task automatic set_group(input logic [31:0] bytes, input logic [3:0] v);
    for (int i = 0; i < 4; i++) begin
      din[i] = bytes[8*i +: 8];
      vin[i] = v[i];
    end
  endtask

  task automatic junk_inputs();
    for (int i = 0; i < 4; i++) begin
      din[i] = 8'($urandom);
      vin[i] = 1'($urandom);
    end
  endtask

  // Fixed-value checks independent of the model for the key plan points.
  task automatic expect_slot(input string tag, input logic [7:0] d, input logic v,
                             input logic [1:0] l, input logic a);
    chk({tag, ".fix_data"},   32'(data_out),  32'(d));
    chk({tag, ".fix_valid"},  32'(valid_out), 32'(v));
    chk({tag, ".fix_lane"},   32'(lane_idx),  32'(l));
    chk({tag, ".fix_active"}, 32'(active),    32'(a));
  endtask

  initial begin
    reset      = 1'b1;
    in_valid   = 1'b0;
    cur        = '0;
    cur_active = 1'b0;
    set_group(32'h0, 4'h0);
    @(negedge clk);

    // Reset state.
    tick("rst0");
    tick("rst1");
    expect_slot("rst", 8'h00, 1'b0, 2'd0, 1'b0);
    reset = 1'b0;
    tick("idle0");

    // Single group, all lanes valid.
    set_group(32'h44332211, 4'hF);
    in_valid = 1'b1;
    tick("single.l0");
    expect_slot("single.l0", 8'h11, 1'b1, 2'd0, 1'b1);
    in_valid = 1'b0;
    tick("single.l1");
    tick("single.l2");
    tick("single.l3");
    expect_slot("single.l3", 8'h44, 1'b1, 2'd3, 1'b1);
    tick("single.idle");
    expect_slot("single.idle", 8'h00, 1'b0, 2'd0, 1'b0);
    #1 chk("single.ready_after", 32'(in_ready), 32'd1);

    // Back-to-back groups with in_valid held and data changing while busy.
    in_valid = 1'b1;
    set_group(32'hA3A2A1A0, 4'hF);
    tick("b2b.a0");
    for (int k = 1; k < 4; k++) begin
      junk_inputs();
      tick("b2b.abusy");
    end
    set_group(32'hB3B2B1B0, 4'hF);
    tick("b2b.b0");
    expect_slot("b2b.b0", 8'hB0, 1'b1, 2'd0, 1'b1);
    for (int k = 1; k < 4; k++) begin
      junk_inputs();
      tick("b2b.bbusy");
    end
    expect_slot("b2b.b3", 8'hB3, 1'b1, 2'd3, 1'b1);
    in_valid = 1'b0;
    tick("b2b.idle");

    // Masked lane 1.
    set_group(32'hDDCCBBAA, 4'b1101);
    in_valid = 1'b1;
    tick("mask.l0");
    in_valid = 1'b0;
    tick("mask.l1");
    expect_slot("mask.l1", 8'h00, 1'b0, 2'd1, 1'b1);
    tick("mask.l2");
    expect_slot("mask.l2", 8'hCC, 1'b1, 2'd2, 1'b1);
    tick("mask.l3");
    tick("mask.idle");

    // Empty group.
    set_group(32'h5A5A5A5A, 4'h0);
    in_valid = 1'b1;
    tick("empty.l0");
    in_valid = 1'b0;
    for (int k = 1; k < 4; k++) tick("empty.ln");
    expect_slot("empty.l3", 8'h00, 1'b0, 2'd3, 1'b1);
    tick("empty.idle");

    // Reset during the lane-1 slot.
    set_group(32'h99887766, 4'hF);
    in_valid = 1'b1;
    tick("rmid.l0");
    in_valid = 1'b0;
    tick("rmid.l1");
    reset = 1'b1;
    tick("rmid.rst");
    expect_slot("rmid.rst", 8'h00, 1'b0, 2'd0, 1'b0);
    reset = 1'b0;
    set_group(32'h04030201, 4'hF);
    in_valid = 1'b1;
    tick("rmid.new0");
    expect_slot("rmid.new0", 8'h01, 1'b1, 2'd0, 1'b1);
    in_valid = 1'b0;
    for (int k = 1; k < 4; k++) tick("rmid.newn");
    expect_slot("rmid.new3", 8'h04, 1'b1, 2'd3, 1'b1);
    tick("rmid.idle");

    // Randomized traffic with occasional reset.
    for (int n = 0; n < 400; n++) begin
      junk_inputs();
      in_valid = ($urandom_range(0, 3) != 0);
      reset    = ($urandom_range(0, 39) == 0);
      tick("rand");
    end
    reset    = 1'b0;
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) tick("drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
